regfile_serial_ctrl: RTL
========================

// Module: regfile_serial_ctrl
// PURPOSE
//  Serial-to-parallel access controller for the PLL control register file.
//  Decodes 16-bit frames from a synchronous 3-wire port (sen/sdi/sdo) and turns
//  them into single-cycle write strobes (rf_wre/rf_addr/rf_din), or serial
//  read-back of rf_dout. It is the only master of the register file. Sits
//  between the chip-level serial pads and the register file in the digital top.
// PARAMETERS
//  REGCOUNT  14  number of implemented registers; addr >= REGCOUNT is illegal
//  FRAME_LEN 16  frame length in bits; fixed, the only legal value
// PORTS
//  sclk       in   1  clock, free-running; all logic on posedge
//  rstn       in   1  reset, asynchronous, active-low
//  sen        in   1  frame enable, active-high, synchronous to sclk
//  sdi        in   1  serial data in, MSB first, sampled at posedge while sen=1
//  sdo        out  1  serial read data, MSB first
//  sdo_oe     out  1  pad output enable for sdo
//  rf_wre     out  1  register-file write strobe, one cycle
//  rf_addr    out  8  register-file address, registered, held between frames
//  rf_din     out  8  register-file write data, registered
//  rf_dout    in   8  register-file read data, combinational from rf_addr
//  busy       out  1  high from first frame bit until the FSM is back in IDLE
//  frame_err  out  1  one-cycle pulse: frame aborted (sen low before bit 16)
//  addr_err   out  1  one-cycle pulse: complete frame with addr >= REGCOUNT
// BEHAVIOUR
//  Frame, sdi bit order: b0 = R/Wn (1 = write), b1..b7 = addr[6:0] MSB first,
//   b8..b15 = data[7:0] MSB first. rf_addr = {1'b0, addr[6:0]}.
//  Bit counter cnt[3:0] counts the sampled bits of the current frame.
//  FSM states: IDLE, CMD, DATA, WRITE, HOLD.
//   IDLE : sen=1 -> rw<=sdi, cnt<=1, go CMD. Otherwise stay.
//   CMD  : sen=1 -> shift sdi into addr shifter, cnt++.
//          The edge that samples b7 loads rf_addr and goes DATA.
//          sen=0 -> frame_err pulse, go IDLE; rf_addr unchanged.
//   DATA : sen=1 -> shift sdi into data shifter, cnt++.
//          The edge that samples b15 loads rf_din. Go WRITE if rw=1 and the
//          addr is legal. Otherwise go HOLD; an illegal addr also pulses addr_err.
//          sen=0 -> frame_err pulse, go IDLE; no write.
//   WRITE: rf_wre=1 for exactly this one cycle, independent of sen.
//          Next state HOLD.
//   HOLD : bits after b15 are ignored. sen=0 -> go IDLE.
//  Write latency: rf_wre is high in the cycle right after the edge that
//   samples b15.
//  Read: during the DATA-state cycle with cnt = 8+k (k = 0..7),
//   sdo = rf_dout[7-k] and sdo_oe = 1 when rw=0. sdo is combinational from
//   the held rf_addr and cnt. An illegal addr reads 0x00. Outside read DATA
//   cycles, sdo = 0 and sdo_oe = 0.
//  A back-to-back frame needs at least one sen=0 cycle (HOLD -> IDLE) first.
//  busy = (state != IDLE). frame_err and addr_err are Moore pulses, one cycle
//   each, registered.
//  Reset (async): state=IDLE, cnt=0, rw=0. All outputs 0: rf_wre, rf_addr,
//   rf_din, sdo, sdo_oe, busy, frame_err, addr_err. A reset mid-frame or during
//   WRITE discards the frame and kills the rf_wre pulse.
// TESTING
//  Write frame 1_0000010_0xA5 -> single rf_wre cycle, rf_addr=0x02, rf_din=0xA5.
//  Then read frame 0_0000010 -> sdo carries 1010_0101 over 8 DATA cycles,
//   sdo_oe=1 in those cycles only, rf_wre stays 0.
//  Write to addr 0x0E (=REGCOUNT) -> no rf_wre, one addr_err pulse.
//   Read of 0x0E -> sdo all 0.
//  sen drops after 10 bits of a write -> frame_err pulse, no rf_wre, busy=0
//   on the next cycle; the next frame decodes normally.
//  sen held high 20 cycles with a write to 0x0D -> exactly one rf_wre.
//   Extra bits are ignored; IDLE after sen falls.
//  rstn asserted in the WRITE cycle and during CMD -> all outputs 0
//   immediately, rf_wre never seen.
//   Back-to-back frames separated by one sen=0 cycle -> both decoded.

Source files
------------

// File: rtl/regfile_serial_ctrl.sv
// Serial 3-wire access controller for the PLL control register file.
// Decodes 16-bit R/Wn + addr + data frames into write strobes or serial read-back.
module regfile_serial_ctrl #(
  parameter int REGCOUNT  = 14,
  parameter int FRAME_LEN = 16
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       sen,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_oe,
  output logic       rf_wre,
  output logic [7:0] rf_addr,
  output logic [7:0] rf_din,
  input  logic [7:0] rf_dout,
  output logic       busy,
  output logic       frame_err,
  output logic       addr_err
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, WRITE, HOLD} state_t;

  localparam logic [3:0] ADDR_LAST = 4'd7;
  localparam logic [3:0] DATA_LAST = 4'(FRAME_LEN - 1);
  localparam logic [7:0] REG_LIMIT = 8'(REGCOUNT);

  state_t     state;
  logic [3:0] cnt;
  logic       rw;
  logic [5:0] addr_sh;
  logic [6:0] data_sh;
  logic       addr_legal;
  logic       rd_phase;
  logic [2:0] bit_sel;

  assign addr_legal = (rf_addr < REG_LIMIT);

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rw        <= 1'b0;
      addr_sh   <= 6'd0;
      data_sh   <= 7'd0;
      rf_addr   <= 8'd0;
      rf_din    <= 8'd0;
      rf_wre    <= 1'b0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      rf_wre    <= 1'b0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sen) begin
            rw    <= sdi;
            cnt   <= 4'd1;
            state <= CMD;
          end
        end
        CMD: begin
          if (sen) begin
            addr_sh <= {addr_sh[4:0], sdi};
            cnt     <= cnt + 4'd1;
            if (cnt == ADDR_LAST) begin
              rf_addr <= {1'b0, addr_sh, sdi};
              state   <= DATA;
            end
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        DATA: begin
          if (sen) begin
            data_sh <= {data_sh[5:0], sdi};
            cnt     <= cnt + 4'd1;
            // The strobe is raised together with the WRITE transition so it lives exactly one cycle
            if (cnt == DATA_LAST) begin
              rf_din   <= {data_sh, sdi};
              addr_err <= !addr_legal;
              if (rw && addr_legal) begin
                rf_wre <= 1'b1;
                state  <= WRITE;
              end else begin
                state <= HOLD;
              end
            end
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        WRITE: state <= HOLD;
        HOLD: begin
          if (!sen) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In DATA, cnt runs 8..15, so its low bits select the read-back bit MSB first
  assign rd_phase = (state == DATA) && !rw;
  assign bit_sel  = 3'd7 - cnt[2:0];
  assign sdo_oe   = rd_phase;
  assign sdo      = rd_phase && addr_legal && rf_dout[bit_sel];
  assign busy     = (state != IDLE);

endmodule
